weight_stage_buffer: RTL and testbench

- Sits directly downstream of the kernel loader and feeds the weight-stationary systolic array.
- Captures the row-wise weight stream (store_weight_req + weight row) into a SIZE×SIZE shadow bank and applies rhs zero-point correction with saturation.
- On request from the compute controller, commits the shadow bank atomically into the active bank that drives every PE.
- Double buffering lets the next weight tile load while the current tile computes.

---
 rtl/weight_stage_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_weight_stage_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stage_buffer.sv
// Double-buffered weight stage between the kernel loader and the systolic array.
// Rows are zero-point corrected on capture into the shadow bank; a swap commits the whole tile at once.
module weight_stage_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int REG_WIDTH  = 32,
    parameter int OUT_WIDTH  = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_cfg_i,
    input  logic [REG_WIDTH-1:0]           rhs_zp_i,
    input  logic                           store_weight_req_i,
    input  logic [SIZE*DATA_WIDTH-1:0]     weight_in_i,
    input  logic                           weight_sending_done_i,
    output logic                           shadow_ready_o,
    output logic                           shadow_full_o,
    input  logic                           swap_req_i,
    output logic                           swap_ack_o,
    output logic                           active_valid_o,
    output logic [SIZE*SIZE*OUT_WIDTH-1:0] pe_weight_o,
    output logic                           overflow_err_o
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int ROW_W = $clog2(SIZE + 1);
    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(SIZE);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic signed [REG_WIDTH:0] SAT_MAX =
        {{(REG_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [REG_WIDTH:0] SAT_MIN =
        {{(REG_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       wr_row_q, wr_row_d;
    logic [REG_WIDTH-1:0]   zp_q;
    logic                   swap_ack_q;
    logic                   active_valid_q;
    logic                   err_q;
    logic [OUT_WIDTH-1:0]   shadow_q [SIZE][SIZE];
    logic [OUT_WIDTH-1:0]   active_q [SIZE][SIZE];
    logic [OUT_WIDTH-1:0]   corr_row_s [SIZE];
    logic [IDX_W-1:0]       wr_sel_s;
    logic                   do_write_s;
    logic                   clear_shadow_s;
    logic                   do_swap_s;
    logic                   set_err_s;

    // Difference is formed one bit wider than the zero point so it can never wrap before clamping.
    function automatic logic [OUT_WIDTH-1:0] zp_correct(
        input logic [DATA_WIDTH-1:0] w,
        input logic [REG_WIDTH-1:0]  zp
    );
        logic signed [REG_WIDTH:0] diff;
        diff = $signed({{(REG_WIDTH + 1 - DATA_WIDTH){w[DATA_WIDTH-1]}}, w})
             - $signed({zp[REG_WIDTH-1], zp});
        if (diff > SAT_MAX) begin
            zp_correct = SAT_MAX[OUT_WIDTH-1:0];
        end else if (diff < SAT_MIN) begin
            zp_correct = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            zp_correct = diff[OUT_WIDTH-1:0];
        end
    endfunction

    // Corrected image of the incoming row.
    always_comb begin
        for (int c = 0; c < SIZE; c++) begin
            corr_row_s[c] = zp_correct(weight_in_i[c*DATA_WIDTH +: DATA_WIDTH], zp_q);
        end
    end

    // Shadow-bank state machine: next state, write/clear/swap strobes and error detection.
    always_comb begin
        state_d        = state_q;
        wr_row_d       = wr_row_q;
        wr_sel_s       = {IDX_W{1'b0}};
        do_write_s     = 1'b0;
        clear_shadow_s = 1'b0;
        do_swap_s      = 1'b0;
        set_err_s      = 1'b0;
        if (init_cfg_i) begin
            state_d  = ST_EMPTY;
            wr_row_d = {ROW_W{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    // A new tile wipes leftovers so unwritten rows read as zero.
                    if (store_weight_req_i) begin
                        do_write_s     = 1'b1;
                        clear_shadow_s = 1'b1;
                        wr_row_d       = ROW_ONE;
                        state_d        = weight_sending_done_i ? ST_FULL : ST_FILLING;
                    end else if (weight_sending_done_i) begin
                        clear_shadow_s = 1'b1;
                        state_d        = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FILLING: begin
                    if (store_weight_req_i) begin
                        if (wr_row_q == ROW_LIMIT) begin
                            set_err_s = 1'b1;
                        end else begin
                            do_write_s = 1'b1;
                            wr_sel_s   = wr_row_q[IDX_W-1:0];
                            wr_row_d   = wr_row_q + ROW_ONE;
                        end
                    end else begin
                        wr_row_d = wr_row_q;
                    end
                    if (weight_sending_done_i) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_FILLING;
                    end
                end
                ST_FULL: begin
                    set_err_s = store_weight_req_i;
                    if (swap_req_i) begin
                        do_swap_s = 1'b1;
                        state_d   = ST_EMPTY;
                        wr_row_d  = {ROW_W{1'b0}};
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    wr_row_d = {ROW_W{1'b0}};
                end
            endcase
        end
    end

    // State, row pointer, zero point and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            wr_row_q       <= {ROW_W{1'b0}};
            zp_q           <= {REG_WIDTH{1'b0}};
            swap_ack_q     <= 1'b0;
            active_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_row_q   <= wr_row_d;
            swap_ack_q <= do_swap_s;
            if (init_cfg_i) begin
                zp_q           <= rhs_zp_i;
                active_valid_q <= 1'b0;
                err_q          <= 1'b0;
            end else begin
                if (do_swap_s) begin
                    active_valid_q <= 1'b1;
                end
                if (set_err_s) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Shadow and active banks; the row write follows the clear so it wins on the first-row edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    shadow_q[r][c] <= {OUT_WIDTH{1'b0}};
                    active_q[r][c] <= {OUT_WIDTH{1'b0}};
                end
            end
        end else if (init_cfg_i) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    shadow_q[r][c] <= {OUT_WIDTH{1'b0}};
                    active_q[r][c] <= {OUT_WIDTH{1'b0}};
                end
            end
        end else begin
            if (clear_shadow_s) begin
                for (int r = 0; r < SIZE; r++) begin
                    for (int c = 0; c < SIZE; c++) begin
                        shadow_q[r][c] <= {OUT_WIDTH{1'b0}};
                    end
                end
            end
            if (do_write_s) begin
                for (int c = 0; c < SIZE; c++) begin
                    shadow_q[wr_sel_s][c] <= corr_row_s[c];
                end
            end
            if (do_swap_s) begin
                active_q <= shadow_q;
            end
        end
    end

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            assign pe_weight_o[(r*SIZE + c)*OUT_WIDTH +: OUT_WIDTH] = active_q[r][c];
        end
    end

    assign shadow_ready_o = (state_q == ST_EMPTY);
    assign shadow_full_o  = (state_q == ST_FULL);
    assign swap_ack_o     = swap_ack_q;
    assign active_valid_o = active_valid_q;
    assign overflow_err_o = err_q;

endmodule

// File: tb/tb_weight_stage_buffer.sv
// Directed and random stimulus for weight_stage_buffer, checked against a tile-queue reference model.
module tb_weight_stage_buffer;
    localparam int SIZE = 16;
    localparam int DW   = 8;
    localparam int OW   = 9;
    localparam int RW   = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   init_cfg;
    logic [RW-1:0]          rhs_zp;
    logic                   store_weight_req;
    logic [SIZE*DW-1:0]     weight_in;
    logic                   weight_sending_done;
    logic                   shadow_ready;
    logic                   shadow_full;
    logic                   swap_req;
    logic                   swap_ack;
    logic                   active_valid;
    logic [SIZE*SIZE*OW-1:0] pe_weight;
    logic                   overflow_err;

    weight_stage_buffer #(.DATA_WIDTH(DW), .SIZE(SIZE), .REG_WIDTH(RW), .OUT_WIDTH(OW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .init_cfg_i            (init_cfg),
        .rhs_zp_i              (rhs_zp),
        .store_weight_req_i    (store_weight_req),
        .weight_in_i           (weight_in),
        .weight_sending_done_i (weight_sending_done),
        .shadow_ready_o        (shadow_ready),
        .shadow_full_o         (shadow_full),
        .swap_req_i            (swap_req),
        .swap_ack_o            (swap_ack),
        .active_valid_o        (active_valid),
        .pe_weight_o           (pe_weight),
        .overflow_err_o        (overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a tile is the list of corrected rows received so far.
    typedef int row_t [SIZE];
    row_t        tile_q[$];
    int          act [SIZE][SIZE];
    bit          m_open, m_full, m_valid, m_err, m_ack;
    logic [31:0] m_zp;
    int          row_v [SIZE];

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pe_at(input int r, input int c);
        logic signed [OW-1:0] v;
        v = pe_weight[(r*SIZE + c)*OW +: OW];
        return int'(v);
    endfunction

    function automatic int model_corr(input int w, input logic [31:0] zp);
        longint d;
        d = longint'(byte'(w)) - longint'($signed(zp));
        if (d > 255) d = 255;
        if (d < -256) d = -256;
        return int'(d);
    endfunction

    task automatic model_reset();
        tile_q.delete();
        m_open = 0; m_full = 0; m_valid = 0; m_err = 0; m_ack = 0;
        m_zp = 32'd0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) act[r][c] = 0;
    endtask

    task automatic model_step(input bit init, input logic [31:0] zp, input bit st, input bit dn, input bit sw);
        m_ack = 0;
        if (init) begin
            model_reset();
            m_zp = zp;
        end else if (m_full) begin
            if (st) m_err = 1;
            if (sw) begin
                for (int r = 0; r < SIZE; r++)
                    for (int c = 0; c < SIZE; c++)
                        act[r][c] = (r < tile_q.size()) ? tile_q[r][c] : 0;
                tile_q.delete();
                m_valid = 1; m_ack = 1; m_full = 0; m_open = 0;
            end
        end else begin
            if (st) begin
                if (tile_q.size() == SIZE) begin
                    m_err = 1;
                end else begin
                    row_t nr;
                    for (int c = 0; c < SIZE; c++) nr[c] = model_corr(row_v[c], m_zp);
                    tile_q.push_back(nr);
                end
                m_open = 1;
            end
            if (dn) begin
                m_full = 1; m_open = 0;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        int fr, fc;
        fr = 0; fc = 0;
        check({ph, ":ready"}, shadow_ready, (!m_open && !m_full) ? 1 : 0);
        check({ph, ":full"}, shadow_full, m_full);
        check({ph, ":ack"}, swap_ack, m_ack);
        check({ph, ":valid"}, active_valid, m_valid);
        check({ph, ":err"}, overflow_err, m_err);
        for (int r = SIZE - 1; r >= 0; r--)
            for (int c = SIZE - 1; c >= 0; c--)
                if (pe_at(r, c) != act[r][c]) begin fr = r; fc = c; end
        check($sformatf("%s:pe[%0d][%0d]", ph, fr, fc), pe_at(fr, fc), act[fr][fc]);
    endtask

    task automatic step(input bit init, input logic [31:0] zp, input bit st, input bit dn, input bit sw,
                        input string ph);
        init_cfg = init; rhs_zp = zp; store_weight_req = st;
        weight_sending_done = dn; swap_req = sw;
        for (int c = 0; c < SIZE; c++) weight_in[c*DW +: DW] = DW'(row_v[c]);
        @(posedge clk); #1;
        model_step(init, zp, st, dn, sw);
        check_outputs(ph);
    endtask

    task automatic rand_row();
        for (int c = 0; c < SIZE; c++) row_v[c] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic const_row(input int v);
        for (int c = 0; c < SIZE; c++) row_v[c] = v;
    endtask

    task automatic idle(input string ph);
        step(0, 32'd0, 0, 0, 0, ph);
    endtask

    initial begin
        logic [31:0] zp;
        rst_n = 1'b0; init_cfg = 0; rhs_zp = 32'd0; store_weight_req = 0;
        weight_sending_done = 0; swap_req = 0; weight_in = '0;
        const_row(0);
        model_reset();
        #3;
        check_outputs("reset");
        #9 rst_n = 1'b1;
        idle("post_reset");

        // Basic fill and swap
        step(1, 32'd0, 0, 0, 0, "init0");
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) row_v[c] = r*16 + c;
            step(0, 32'd0, 1, 0, 0, "basic_fill");
        end
        step(0, 32'd0, 0, 1, 0, "basic_done");
        step(0, 32'd0, 0, 0, 1, "basic_swap");
        check("basic_pe35", pe_at(3, 5), 53);
        step(0, 32'd0, 0, 0, 0, "basic_after");

        // Zero point and saturation
        step(1, 32'hFFFF_FF80, 0, 0, 0, "init_zp_m128");
        rand_row(); row_v[0] = 127; row_v[1] = -128;
        step(0, 32'd0, 1, 1, 0, "zp_store_done");
        step(0, 32'd0, 0, 0, 1, "zp_swap");
        check("zp_127", pe_at(0, 0), 255);
        check("zp_m128", pe_at(0, 1), 0);
        step(1, 32'd200, 0, 0, 0, "init_zp_200");
        rand_row(); row_v[0] = -128;
        step(0, 32'd0, 1, 1, 0, "sat_store_done");
        step(0, 32'd0, 0, 0, 1, "sat_swap");
        check("sat_low", pe_at(0, 0), -256);

        // Partial tile over an older full tile
        step(1, 32'd0, 0, 0, 0, "init_partial");
        const_row(9);
        for (int r = 0; r < SIZE; r++) step(0, 32'd0, 1, 0, 0, "nines");
        step(0, 32'd0, 0, 1, 1, "nines_done");
        step(0, 32'd0, 0, 0, 1, "nines_swap");
        const_row(7);
        for (int r = 0; r < 5; r++) step(0, 32'd0, 1, 0, 0, "sevens");
        step(0, 32'd0, 0, 1, 0, "sevens_done");
        step(0, 32'd0, 0, 0, 1, "sevens_swap");
        check("partial_row4", pe_at(4, 0), 7);
        check("partial_row5", pe_at(5, 15), 0);

        // Swap requested early while the tile is still filling
        step(1, 32'd3, 0, 0, 0, "init_overlap");
        for (int r = 0; r < 14; r++) begin
            rand_row();
            step(0, 32'd0, 1, 0, (r >= 10) ? 1'b1 : 1'b0, "overlap_fill");
        end
        step(0, 32'd0, 0, 1, 1, "overlap_done");
        step(0, 32'd0, 0, 0, 1, "overlap_swap");
        check("overlap_ack", swap_ack, 1);
        idle("overlap_idle");

        // Overflow by row count, then store into a full shadow bank
        step(1, 32'd0, 0, 0, 0, "init_ovf");
        for (int r = 0; r < 17; r++) begin
            rand_row();
            step(0, 32'd0, 1, 0, 0, "ovf_fill");
        end
        check("ovf_flag", overflow_err, 1);
        step(0, 32'd0, 0, 1, 0, "ovf_done");
        step(0, 32'd0, 0, 0, 1, "ovf_swap");
        step(1, 32'd0, 0, 0, 0, "init_ovf2");
        check("ovf_cleared", overflow_err, 0);
        for (int r = 0; r < 3; r++) begin rand_row(); step(0, 32'd0, 1, 0, 0, "full_fill"); end
        step(0, 32'd0, 0, 1, 0, "full_done");
        step(0, 32'd0, 1, 1, 0, "full_store");
        check("full_store_flag", overflow_err, 1);
        step(1, 32'd0, 0, 0, 0, "init_clear");

        // Zero-row tile
        step(0, 32'd0, 0, 1, 0, "zero_done");
        step(0, 32'd0, 0, 0, 1, "zero_swap");

        // Asynchronous reset in the middle of a fill
        step(1, 32'd5, 0, 0, 0, "init_rst");
        for (int r = 0; r < 4; r++) begin rand_row(); step(0, 32'd0, 1, 0, 0, "pre_fill"); end
        step(0, 32'd0, 0, 1, 1, "pre_done");
        step(0, 32'd0, 0, 0, 1, "pre_swap");
        for (int r = 0; r < 8; r++) begin rand_row(); step(0, 32'd0, 1, 0, 0, "rst_fill"); end
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("async_rst");
        #2 rst_n = 1'b1;
        idle("rst_idle");

        // init_cfg beats a coincident swap
        step(1, 32'd0, 0, 0, 0, "init_prio");
        for (int r = 0; r < 4; r++) begin rand_row(); step(0, 32'd0, 1, 0, 0, "prio_a"); end
        step(0, 32'd0, 0, 1, 0, "prio_a_done");
        step(0, 32'd0, 0, 0, 1, "prio_a_swap");
        for (int r = 0; r < 4; r++) begin rand_row(); step(0, 32'd0, 1, 0, 0, "prio_b"); end
        step(0, 32'd0, 0, 1, 0, "prio_b_done");
        step(1, 32'd0, 0, 0, 1, "prio_init_swap");
        check("prio_no_ack", swap_ack, 0);
        check("prio_valid", active_valid, 0);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            bit ini, st, dn, sw;
            ini = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 55);
            dn  = ($urandom_range(0, 99) < 12);
            sw  = ($urandom_range(0, 99) < 40);
            case ($urandom_range(0, 3))
                0: zp = 32'd0;
                1: zp = 32'(int'($urandom_range(0, 300)) - 150);
                2: zp = $urandom;
                default: zp = 32'hFFFF_FF80;
            endcase
            rand_row();
            step(ini, zp, st, dn, sw, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
